// File: rtl/spi_master.sv
// Byte-wide SPI master, mode 0 (CPOL=0, CPHA=0), MSB first.
// SCLK is derived from sys_clk; each SCLK half-period lasts CLK_DIV sys_clk cycles.
// Optional feature: define SPI_MASTER_BURST_EN to let a start request in the last
// HOLD cycle chain the next byte without releasing ss. Leave it undefined to frame
// every byte with its own ss pulse.
module spi_master #(
  parameter int unsigned CLK_DIV = 4  // legal range 1..255
) (
  input  logic       sys_clk,
  input  logic       rst,
  input  logic       start,
  input  logic [7:0] tx_data,
  output logic       busy,
  output logic [7:0] rx_data,
  output logic       data_rdy,
  output logic       ss,
  output logic       sclk,
  output logic       mosi,
  input  logic       miso
);

  typedef enum logic [2:0] {StIdle, StSetup, StXfer, StHold, StGap} state_e;

  localparam logic [7:0] HcntMax = 8'(CLK_DIV - 1);

  state_e     state_q, state_d;
  logic [7:0] hcnt_q, hcnt_d;
  logic [2:0] bcnt_q, bcnt_d;
  logic [7:0] shreg_q, shreg_d;
  logic [7:0] rx_q, rx_d;
  logic       busy_q, busy_d;
  logic       rdy_q, rdy_d;
  logic       ss_q, ss_d;
  logic       sclk_q, sclk_d;
  logic       mosi_q, mosi_d;
  logic       hexp;

  // Last cycle of the current half-period / phase.
  assign hexp = (hcnt_q == HcntMax);

  // Next-state and registered-output logic.
  always_comb begin
    state_d = state_q;
    hcnt_d  = hexp ? 8'd0 : hcnt_q + 8'd1;
    bcnt_d  = bcnt_q;
    shreg_d = shreg_q;
    rx_d    = rx_q;
    busy_d  = busy_q;
    rdy_d   = 1'b0;
    ss_d    = ss_q;
    sclk_d  = sclk_q;
    mosi_d  = mosi_q;
    case (state_q)
      StIdle: begin
        hcnt_d = 8'd0;
        if (start) begin
          shreg_d = tx_data;
          mosi_d  = tx_data[7];
          ss_d    = 1'b0;
          busy_d  = 1'b1;
          bcnt_d  = 3'd0;
          state_d = StSetup;
        end
      end
      StSetup: begin
        if (hexp) state_d = StXfer;
      end
      StXfer: begin
        if (hexp) begin
          if (!sclk_q) begin
            // Rising edge: the only point where miso is sampled.
            sclk_d  = 1'b1;
            shreg_d = {shreg_q[6:0], miso};
          end else begin
            sclk_d = 1'b0;
            if (bcnt_q == 3'd7) begin
              state_d = StHold;
            end else begin
              // After the shift, shreg[7] already holds the next bit to send.
              mosi_d = shreg_q[7];
              bcnt_d = bcnt_q + 3'd1;
            end
          end
        end
      end
      StHold: begin
        if (hexp) begin
          rx_d  = shreg_q;
          rdy_d = 1'b1;
`ifdef SPI_MASTER_BURST_EN
          if (start) begin
            shreg_d = tx_data;
            mosi_d  = tx_data[7];
            bcnt_d  = 3'd0;
            state_d = StSetup;
          end else begin
            ss_d    = 1'b1;
            state_d = StGap;
          end
`else
          ss_d    = 1'b1;
          state_d = StGap;
`endif
        end
      end
      StGap: begin
        if (hexp) begin
          busy_d  = 1'b0;
          state_d = StIdle;
        end
      end
      default: state_d = StIdle;
    endcase
  end

  // State and output registers; reset aborts any transfer without a data_rdy pulse.
  always_ff @(posedge sys_clk) begin
    if (rst) begin
      state_q <= StIdle;
      hcnt_q  <= 8'd0;
      bcnt_q  <= 3'd0;
      shreg_q <= 8'h00;
      rx_q    <= 8'h00;
      busy_q  <= 1'b0;
      rdy_q   <= 1'b0;
      ss_q    <= 1'b1;
      sclk_q  <= 1'b0;
      mosi_q  <= 1'b0;
    end else begin
      state_q <= state_d;
      hcnt_q  <= hcnt_d;
      bcnt_q  <= bcnt_d;
      shreg_q <= shreg_d;
      rx_q    <= rx_d;
      busy_q  <= busy_d;
      rdy_q   <= rdy_d;
      ss_q    <= ss_d;
      sclk_q  <= sclk_d;
      mosi_q  <= mosi_d;
    end
  end

  assign busy     = busy_q;
  assign rx_data  = rx_q;
  assign data_rdy = rdy_q;
  assign ss       = ss_q;
  assign sclk     = sclk_q;
  assign mosi     = mosi_q;

endmodule

// File: tb/tb_spi_master.sv
// Scoreboard bench for spi_master: one instance with CLK_DIV=4, one with CLK_DIV=1.
module tb_spi_master;

  typedef struct {
    int rx;
    int cyc;
  } exp_t;

`ifdef SPI_MASTER_BURST_EN
  localparam int Gap2   = 72;  // second byte accepted in the last HOLD cycle
  localparam int SsHiEx = 0;
`else
  localparam int Gap2   = 77;  // second byte accepted the cycle after busy falls
  localparam int SsHiEx = 5;
`endif

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic       rst = 1'b1;
  logic       start4 = 1'b0, start1 = 1'b0;
  logic [7:0] tx4 = 8'h00, tx1 = 8'h00;
  logic       busy4, rdy4, ss4, sclk4, mosi4, miso4;
  logic       busy1, rdy1, ss1, sclk1, mosi1;
  logic [7:0] rx4, rx1;
  logic       loop4 = 1'b1;
  logic [7:0] slv_reg = 8'h3C;

  int cyc = 0;
  int n_chk = 0, n_fail = 0;
  exp_t q4[$], q1[$];

  assign miso4 = loop4 ? mosi4 : slv_reg[7];

  spi_master #(.CLK_DIV(4)) u_dut4 (
    .sys_clk(clk), .rst(rst), .start(start4), .tx_data(tx4), .busy(busy4), .rx_data(rx4),
    .data_rdy(rdy4), .ss(ss4), .sclk(sclk4), .mosi(mosi4), .miso(miso4)
  );

  spi_master #(.CLK_DIV(1)) u_dut1 (
    .sys_clk(clk), .rst(rst), .start(start1), .tx_data(tx1), .busy(busy1), .rx_data(rx1),
    .data_rdy(rdy1), .ss(ss1), .sclk(sclk1), .mosi(mosi1), .miso(mosi1)
  );

  // Mode-0 slave: presents its MSB when selected, shifts on each falling sclk.
  always @(negedge ss4) slv_reg = 8'h3C;
  always @(negedge sclk4) slv_reg = {slv_reg[6:0], 1'b0};

  always @(posedge clk) cyc <= cyc + 1;

  task automatic chk(input string name, input int act, input int exp);
    n_chk++;
    if (act != exp) begin
      n_fail++;
      $display("FAIL %s: got %0d (0x%0h), expected %0d (0x%0h) at cycle %0d",
               name, act, act, exp, exp, cyc);
    end
  endtask

  // Activity trackers.
  logic sclk4_p = 1'b0, mosi4_p = 1'b0, sclk1_p = 1'b0, mosi1_p = 1'b0;
  int rise4 = 0, viol4 = 0, mosihi4 = 0, rdycnt4 = 0;
  int rise1 = 0, viol1 = 0;
  int rise1_t[2];
  always @(negedge clk) begin
    if (sclk4 && !sclk4_p) begin
      rise4++;
      if (mosi4 !== mosi4_p) viol4++;
    end
    if (sclk1 && !sclk1_p) begin
      if (rise1 < 2) rise1_t[rise1] = cyc;
      rise1++;
      if (mosi1 !== mosi1_p) viol1++;
    end
    if (mosi4) mosihi4++;
    if (rdy4) rdycnt4++;
    sclk4_p = sclk4;
    mosi4_p = mosi4;
    sclk1_p = sclk1;
    mosi1_p = mosi1;
  end

  // Scoreboard monitors: every data_rdy pulse must match the head of its queue.
  always @(negedge clk) begin
    exp_t e;
    if (rdy4 === 1'b1) begin
      chk("rdy4_expected", int'(q4.size() > 0), 1);
      if (q4.size() > 0) begin
        e = q4.pop_front();
        chk("rx4", int'(rx4), e.rx);
        chk("rdy4_cycle", cyc, e.cyc);
      end
    end
    if (rdy1 === 1'b1) begin
      chk("rdy1_expected", int'(q1.size() > 0), 1);
      if (q1.size() > 0) begin
        e = q1.pop_front();
        chk("rx1", int'(rx1), e.rx);
        chk("rdy1_cycle", cyc, e.cyc);
      end
    end
  end

  task automatic wait_cyc(input int c);
    while (cyc < c) @(negedge clk);
  endtask

  task automatic send4(input logic [7:0] tx, input bit expect_rdy, input int exp_rx,
                       output int t0);
    exp_t e;
    @(negedge clk);
    start4 = 1'b1;
    tx4    = tx;
    t0     = cyc + 1;
    if (expect_rdy) begin
      e.rx  = exp_rx;
      e.cyc = t0 + 72;
      q4.push_back(e);
    end
    @(negedge clk);
    start4  = 1'b0;
    rise4   = 0;
    mosihi4 = 0;
  endtask

  task automatic wait_idle4(output int tf);
    int n = 0;
    while (busy4 === 1'b1 && n < 400) begin
      @(negedge clk);
      n++;
    end
    tf = cyc;
    if (n >= 400) chk("busy4_timeout", int'(busy4), 0);
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish, cycle %0d", cyc);
    $fatal(1, "watchdog");
  end

  initial begin
    int t0, tf, sshi, n;
    exp_t e;
    repeat (3) @(negedge clk);
    chk("rst_ss", int'(ss4), 1);
    chk("rst_sclk", int'(sclk4), 0);
    chk("rst_mosi", int'(mosi4), 0);
    chk("rst_busy", int'(busy4), 0);
    chk("rst_rdy", int'(rdy4), 0);
    chk("rst_rx", int'(rx4), 0);
    chk("rst_ss1", int'(ss1), 1);
    chk("rst_busy1", int'(busy1), 0);
    rst = 1'b0;

    // Abort mid-byte (bcnt=3, sclk high) with reset.
    send4(8'h5A, 1'b0, 0, t0);
    wait_cyc(t0 + 34);
    chk("abort_busy_before", int'(busy4), 1);
    chk("abort_sclk_before", int'(sclk4), 1);
    rdycnt4 = 0;
    rst = 1'b1;
    @(negedge clk);
    chk("abort_ss", int'(ss4), 1);
    chk("abort_sclk", int'(sclk4), 0);
    chk("abort_busy", int'(busy4), 0);
    chk("abort_rx", int'(rx4), 0);
    rst = 1'b0;
    wait_cyc(t0 + 140);
    chk("abort_rdy_count", rdycnt4, 0);
    chk("abort_ss_idle", int'(ss4), 1);

    // Loopback A5 with timing.
    loop4 = 1'b1;
    send4(8'hA5, 1'b1, 8'hA5, t0);
    wait_idle4(tf);
    chk("t1_busy_fall", tf - t0, 76);
    chk("t1_rises", rise4, 8);

    // Slave returns 3C while master sends 00.
    loop4 = 1'b0;
    send4(8'h00, 1'b1, 8'h3C, t0);
    wait_idle4(tf);
    chk("t2_rises", rise4, 8);
    chk("t2_mosi_high_cycles", mosihi4, 0);
    loop4 = 1'b1;

    // Start pulses during a transfer are ignored.
    send4(8'hC3, 1'b1, 8'hC3, t0);
    wait_cyc(t0 + 9);
    start4 = 1'b1;
    tx4    = 8'hFF;
    @(negedge clk);
    start4 = 1'b0;
    wait_cyc(t0 + 39);
    start4 = 1'b1;
    tx4    = 8'h00;
    @(negedge clk);
    start4 = 1'b0;
    wait_idle4(tf);
    chk("t3_rises", rise4, 8);
    chk("t3_busy_fall", tf - t0, 76);

    // CLK_DIV=1 loopback.
    @(negedge clk);
    start1 = 1'b1;
    tx1    = 8'h81;
    t0     = cyc + 1;
    e.rx   = 8'h81;
    e.cyc  = t0 + 18;
    q1.push_back(e);
    @(negedge clk);
    start1 = 1'b0;
    rise1  = 0;
    n = 0;
    while (busy1 === 1'b1 && n < 100) begin
      @(negedge clk);
      n++;
    end
    chk("t5_busy_fall", cyc - t0, 19);
    chk("t5_rises", rise1, 8);
    chk("t5_first_rise", rise1_t[0] - t0, 2);
    chk("t5_sclk_period", rise1_t[1] - rise1_t[0], 2);

    // Two bytes with start held high.
    @(negedge clk);
    start4 = 1'b1;
    tx4    = 8'h11;
    t0     = cyc + 1;
    e.rx   = 8'h11;
    e.cyc  = t0 + 72;
    q4.push_back(e);
    e.rx   = 8'h22;
    e.cyc  = t0 + Gap2 + 72;
    q4.push_back(e);
    @(negedge clk);
    tx4  = 8'h22;
    sshi = 0;
    while (cyc < t0 + Gap2 + 72) begin
      if (cyc == t0 + Gap2) start4 = 1'b0;
      if (ss4) sshi++;
      @(negedge clk);
    end
    wait_idle4(tf);
    chk("t6_ss_high_cycles", sshi, SsHiEx);

    repeat (10) @(negedge clk);
    chk("q4_drained", q4.size(), 0);
    chk("q1_drained", q1.size(), 0);
    chk("mosi4_stable_at_rise", viol4, 0);
    chk("mosi1_stable_at_rise", viol1, 0);
    $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
    $finish;
  end

endmodule
